serial_magnitude_comparator: RTL and testbench

//  Multi-cycle, bit-serial magnitude/equality comparator; parametrised successor of the ALU

---
 rtl/serial_cmp_pkg.sv | 15 +
 rtl/cmp_bit_cell.sv | 15 +
 rtl/serial_magnitude_comparator.sv | 141 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding
// and the internal result code used while a comparison is in progress.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

endpackage : serial_cmp_pkg

// File: rtl/cmp_bit_cell.sv
// One-bit compare cell. o_diff flags a mismatch; o_gt says A's bit wins.
// i_invert swaps the winner, which is how the sign bit of a two's-complement
// operand is handled (a set sign bit means the smaller value).
module cmp_bit_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_invert,
    output logic o_diff,
    output logic o_gt
);

    assign o_diff = i_a ^ i_b;
    assign o_gt   = o_diff & (i_a ^ i_invert);

endmodule : cmp_bit_cell

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude/equality comparator, MSB first, one bit per clock.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish on the first
// differing bit instead of always scanning all WIDTH bits.
module serial_magnitude_comparator #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    import serial_cmp_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signed;
    logic             r_decided;
    logic [1:0]       r_code;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic             w_accept;
    logic             w_invert;
    logic             w_diff;
    logic             w_bit_gt;
    logic             w_last;
    logic             w_finish;
    logic [1:0]       w_final_code;

    // A request is honoured in IDLE and DONE; while scanning it is ignored.
    assign w_accept = start && (r_state != ST_RUN);
    // Only the sign bit (first bit scanned) of a signed compare is inverted.
    assign w_invert = r_signed && (r_cnt == '0);
    assign w_last   = (r_cnt == LAST_CNT);

    cmp_bit_cell u_cell (
        .i_a      (r_a_sh[WIDTH-1]),
        .i_b      (r_b_sh[WIDTH-1]),
        .i_invert (w_invert),
        .o_diff   (w_diff),
        .o_gt     (w_bit_gt)
    );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign w_finish = w_last || (w_diff && !r_decided);
`else
    assign w_finish = w_last;
`endif

    // Result as it stands after the bit being compared this cycle.
    always_comb begin
        w_final_code = CMP_EQ;
        if (r_decided) begin
            w_final_code = r_code;
        end else if (w_diff) begin
            w_final_code = w_bit_gt ? CMP_GT : CMP_LT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_finish) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, bit counter, running decision and result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_decided <= 1'b0;
            r_code    <= CMP_EQ;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else if (w_accept) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_cnt     <= '0;
            r_signed  <= signed_mode;
            r_decided <= 1'b0;
            r_code    <= CMP_EQ;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a_sh <= {r_a_sh[WIDTH-2:0], 1'b0};
            r_b_sh <= {r_b_sh[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
            // First mismatch decides; later bits never override it.
            if (!r_decided && w_diff) begin
                r_decided <= 1'b1;
                r_code    <= w_final_code;
            end
            // Publish the one-hot result as DONE is entered.
            if (w_finish) begin
                r_eq <= (w_final_code == CMP_EQ);
                r_gt <= (w_final_code == CMP_GT);
                r_lt <= (w_final_code == CMP_LT);
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule : serial_magnitude_comparator

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=5).
// Honours SERIAL_CMP_EARLY_EXIT_EN when computing the expected latency.
module tb_serial_magnitude_comparator;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, eq, gt, lt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    // Reference: expected {eq,gt,lt} from plain integer comparison.
    function automatic logic [2:0] ref_res(logic [W-1:0] x, logic [W-1:0] y, logic s);
        int xv, yv;
        xv = s ? int'($signed(x)) : int'(x);
        yv = s ? int'($signed(y)) : int'(y);
        if (xv == yv) return 3'b100;
        else if (xv > yv) return 3'b010;
        else return 3'b001;
    endfunction

    // Reference: cycles from acceptance to the visible done pulse.
    function automatic int ref_lat(logic [W-1:0] x, logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int j = 1; j <= W; j++) begin
            if (x[W-j] !== y[W-j]) return j;
        end
`endif
        return W;
    endfunction

    // Issue one operation from a negedge and wait (bounded) for done.
    // Operands are scrambled right after acceptance.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         output int lat, output logic [2:0] res,
                         output logic busy0, output logic [2:0] res0, output bit tmo);
        a = ia; b = ib; signed_mode = is; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        busy0 = busy; res0 = {eq, gt, lt};
        lat = 0; res = 3'b000; tmo = 1'b1;
        for (int i = 1; i <= W + 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                lat = i; res = {eq, gt, lt}; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_assert: got %b want 00000", {busy, done, eq, gt, lt});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 00000", {busy, done, eq, gt, lt});
        end
        $display("test_reset: outputs after reset %b", {busy, done, eq, gt, lt});
    endtask

    task automatic test_directed();
        logic [2*W:0] vecs [6];
        int lat; logic [2:0] res, res0; logic busy0; bit tmo;
        logic [W-1:0] va, vb; logic vs;
        vecs[0] = {5'b00001, 5'b00001, 1'b0};
        vecs[1] = {5'b10101, 5'b10100, 1'b0};
        vecs[2] = {5'b11100, 5'b00011, 1'b0};
        vecs[3] = {5'b11100, 5'b00011, 1'b1};
        vecs[4] = {5'b01111, 5'b10000, 1'b1};
        vecs[5] = {5'b10000, 5'b01111, 1'b0};
        for (int v = 0; v < 6; v++) begin
            {va, vb, vs} = vecs[v];
            do_op(va, vb, vs, lat, res, busy0, res0, tmo);
            n_checks++;
            if (tmo) begin
                n_fail++;
                $display("FAIL directed_timeout[%0d]: no done within %0d cycles", v, W + 3);
            end else if (res !== ref_res(va, vb, vs) || lat != ref_lat(va, vb)) begin
                n_fail++;
                $display("FAIL directed[%0d]: got res=%b lat=%0d want res=%b lat=%0d",
                         v, res, lat, ref_res(va, vb, vs), ref_lat(va, vb));
            end
            n_checks++;
            if (busy0 !== 1'b1 || res0 !== 3'b000) begin
                n_fail++;
                $display("FAIL directed_accept[%0d]: got busy=%b res=%b want busy=1 res=000", v, busy0, res0);
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if ({busy, done, eq, gt, lt} !== {2'b00, ref_res(va, vb, vs)}) begin
                n_fail++;
                $display("FAIL directed_hold[%0d]: got %b want %b", v,
                         {busy, done, eq, gt, lt}, {2'b00, ref_res(va, vb, vs)});
            end
            $display("directed[%0d]: a=%b b=%b s=%b res=%b lat=%0d", v, va, vb, vs, res, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [2:0] res, res0; logic busy0; bit tmo;
        logic [W-1:0] ra, rb; logic rs;
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            if (n % 4 == 0) rb = ra;
            do_op(ra, rb, rs, lat, res, busy0, res0, tmo);
            n_checks++;
            if (tmo || res !== ref_res(ra, rb, rs) || lat != ref_lat(ra, rb) ||
                busy0 !== 1'b1 || res0 !== 3'b000) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%b b=%b s=%b got res=%b lat=%0d tmo=%0b busy0=%b res0=%b want res=%b lat=%0d",
                         n, ra, rb, rs, res, lat, tmo, busy0, res0, ref_res(ra, rb, rs), ref_lat(ra, rb));
            end
            $display("random[%0d]: a=%b b=%b s=%b res=%b lat=%0d", n, ra, rb, rs, res, lat);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int lat; logic [2:0] res;
        lat = 0; res = 3'b000;
        @(negedge clk);
        a = 5'b00001; b = 5'b00000; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= W + 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                lat = i; res = {eq, gt, lt};
                break;
            end
            if (i == 1 || i == 2) begin
                start = 1'b1; a = 5'b00000; b = 5'b11111; signed_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (res !== 3'b010 || lat != W) begin
            n_fail++;
            $display("FAIL ignore_start: got res=%b lat=%0d want res=010 lat=%0d", res, lat, W);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        $display("ignore_start: res=%b lat=%0d", res, lat);
    endtask

    task automatic test_back_to_back();
        int done_at [$];
        @(negedge clk);
        a = 5'b01100; b = 5'b01100; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                done_at.push_back(i);
                n_checks++;
                if ({eq, gt, lt} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL b2b_result@%0d: got %b want 100", i, {eq, gt, lt});
                end
            end
            if (i == W + 1) begin
                n_checks++;
                if ({busy, done, eq, gt, lt} !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL b2b_reaccept: got %b want 10000", {busy, done, eq, gt, lt});
                end
            end
            if (i == 2 * W + 1) start = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (done_at.size() != 2 || done_at[0] != W || done_at[1] != 2 * W + 1) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d pulses (first %0d) want 2 at %0d,%0d",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, W, 2 * W + 1);
        end
        $display("back_to_back: done pulses=%0d", done_at.size());
    endtask

    task automatic test_reset_async();
        int lat, ndone; logic [2:0] res, res0; logic busy0; bit tmo;
        // Mid-idle, with a result held.
        do_op(5'b00001, 5'b00001, 1'b0, lat, res, busy0, res0, tmo);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle_async: got %b want 00000", {busy, done, eq, gt, lt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Mid-RUN.
        a = 5'b00000; b = 5'b00001; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_run_pre: got busy=%b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, eq, gt, lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_run_async: got %b want 00000", {busy, done, eq, gt, lt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL reset_run_abort: got %0d busy/done cycles want 0", ndone);
        end
        $display("reset_async: post-abort activity cycles=%0d", ndone);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_magnitude_comparator
